// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD counter link.
//   - digit constants ZERO..NINE
//   - monitor state encoding (HUNT / SYNC / LOCKED)
//   - bcd_succ(d): next digit of the 0..9 cycle
//   - bcd_legal(d): digit is a valid BCD code
package bcd_pkg;

  localparam logic [3:0] ZERO  = 4'd0;
  localparam logic [3:0] ONE   = 4'd1;
  localparam logic [3:0] TWO   = 4'd2;
  localparam logic [3:0] THREE = 4'd3;
  localparam logic [3:0] FOUR  = 4'd4;
  localparam logic [3:0] FIVE  = 4'd5;
  localparam logic [3:0] SIX   = 4'd6;
  localparam logic [3:0] SEVEN = 4'd7;
  localparam logic [3:0] EIGHT = 4'd8;
  localparam logic [3:0] NINE  = 4'd9;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic [3:0] bcd_succ(input logic [3:0] d);
    return (d == NINE) ? ZERO : d + 4'd1;
  endfunction

  function automatic logic bcd_legal(input logic [3:0] d);
    return d <= NINE;
  endfunction

endpackage

// File: rtl/bcd_monitor_if.sv
// bcd_monitor_if: counter link as seen by the monitor.
//   digit/valid : sampled BCD stream (driven by the counter side)
//   locked      : level, monitor locked to the sequence
//   err/illegal/wrap : one-cycle status pulses
//   tens        : BCD count of completed decades while locked
//   err_cnt     : saturating error count
// master = stream source / observer, slave = monitor.
interface bcd_monitor_if #(parameter int ERR_W = 8);
  logic [3:0]       digit;
  logic             valid;
  logic             locked;
  logic             err;
  logic             illegal;
  logic             wrap;
  logic [3:0]       tens;
  logic [ERR_W-1:0] err_cnt;

  modport master (output digit, valid,
                  input  locked, err, illegal, wrap, tens, err_cnt);
  modport slave  (input  digit, valid,
                  output locked, err, illegal, wrap, tens, err_cnt);
endinterface

// File: rtl/bcd_decade_counter.sv
// bcd_decade_counter: one BCD digit (0..9) with clear, enable and carry-out.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : advance one count
//   q          : current digit
//   co         : en while q==9, i.e. this step rolls over into the next digit
module bcd_decade_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       co
);
  import bcd_pkg::*;

  assign co = en && (q == NINE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= ZERO;
    else if (clr) q <= ZERO;
    else if (en)  q <= bcd_succ(q);
  end
endmodule

// File: rtl/bcd_monitor.sv
// bcd_monitor: receive-side checker for the BCD counter stream.
// Hunts for a legal seed, confirms LOCK_COUNT consecutive in-sequence digits,
// then flags sequence breaks (err) and non-BCD codes (illegal), counting
// completed decades (tens) and errors (err_cnt, saturating).
//   clk, reset : clock, async active-low reset
//   bus        : bcd_monitor_if slave (digit/valid in, status out)
module bcd_monitor #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  bcd_monitor_if.slave bus
);
  import bcd_pkg::*;

  localparam logic [3:0]       LC      = 4'(LOCK_COUNT);
  // a fresh legal seed goes straight to LOCKED when one digit is enough
  localparam logic [1:0]       SEED_ST = (LOCK_COUNT == 1) ? ST_LOCKED : ST_SYNC;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state;
  logic [3:0]       run, expected;
  logic             err_q, illegal_q, wrap_q;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       tens;

  logic       legal, match, in_lock, lock_loss, wrap_hit;
  logic [3:0] seed_exp;

  always_comb begin
    legal     = bcd_legal(bus.digit);
    match     = (bus.digit == expected);
    in_lock   = (state == ST_LOCKED);
    // expected is always 0..9, so an illegal digit is always a mismatch
    lock_loss = bus.valid && in_lock && !match;
    wrap_hit  = bus.valid && in_lock && match && (bus.digit == NINE);
    // on a match this equals bcd_succ(expected), so one successor serves both
    seed_exp  = bcd_succ(bus.digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_HUNT;
      run       <= 4'd0;
      expected  <= ZERO;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_q     <= lock_loss;
      illegal_q <= bus.valid && !legal;
      wrap_q    <= wrap_hit;
      if (lock_loss && err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
      if (bus.valid) begin
        case (state)
          ST_HUNT: if (legal) begin
            expected <= seed_exp;
            run      <= 4'd1;
            state    <= SEED_ST;
          end
          ST_SYNC: begin
            if (!legal) state <= ST_HUNT;
            else if (match) begin
              run      <= run + 4'd1;
              expected <= seed_exp;
              if (run + 4'd1 == LC) state <= ST_LOCKED;
            end else begin
              run      <= 4'd1;
              expected <= seed_exp;
            end
          end
          ST_LOCKED: begin
            if (match) expected <= seed_exp;
            else if (legal) begin
              run      <= 4'd1;
              expected <= seed_exp;
              state    <= SEED_ST;
            end else state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  // tens: advances on each in-lock decade, cleared whenever lock is lost
  bcd_decade_counter u_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (lock_loss),
    .en    (wrap_hit),
    .q     (tens),
    .co    ()
  );

  assign bus.locked  = in_lock;
  assign bus.err     = err_q;
  assign bus.illegal = illegal_q;
  assign bus.wrap    = wrap_q;
  assign bus.tens    = tens;
  assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_bcd_monitor.sv
// Bench for bcd_monitor: three instances share one stimulus stream
//   u0: LOCK_COUNT=3 ERR_W=8, u1: LOCK_COUNT=3 ERR_W=2, u2: LOCK_COUNT=1 ERR_W=8.
// A behavioural model pushes expected outputs to a scoreboard queue as each
// digit is driven; entries are popped and compared after the sampling edge.
module tb_bcd_monitor;

  typedef struct packed {
    logic       lk, er, il, wr;
    logic [3:0] tens;
    logic [7:0] ec;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit;
  logic       valid;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  bcd_monitor_if #(.ERR_W(8)) b0 ();
  bcd_monitor_if #(.ERR_W(2)) b1 ();
  bcd_monitor_if #(.ERR_W(8)) b2 ();

  assign b0.digit = digit;  assign b0.valid = valid;
  assign b1.digit = digit;  assign b1.valid = valid;
  assign b2.digit = digit;  assign b2.valid = valid;

  bcd_monitor #(.LOCK_COUNT(3), .ERR_W(8)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  bcd_monitor #(.LOCK_COUNT(3), .ERR_W(2)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  bcd_monitor #(.LOCK_COUNT(1), .ERR_W(8)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

  // ---------------- reference model ----------------
  int lc[3]    = '{3, 3, 1};
  int ecmax[3] = '{255, 3, 255};
  int m_st[3], m_run[3], m_exp[3], m_tens[3], m_ec[3];   // st: 0 hunt, 1 sync, 2 locked
  obs_t sb[$];

  function automatic int nxt(input int d);
    return (d == 9) ? 0 : d + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_run[k] = 0; m_exp[k] = 0; m_tens[k] = 0; m_ec[k] = 0;
    end
  endtask

  task automatic model(input int k, input logic [3:0] d, input logic v, output obs_t e);
    int  di;
    logic er, il, wr;
    di = int'(d); er = 0; il = 0; wr = 0;
    if (v) begin
      il = (di > 9);
      if (m_st[k] == 0) begin
        if (di <= 9) begin
          m_exp[k] = nxt(di); m_run[k] = 1; m_st[k] = (lc[k] == 1) ? 2 : 1;
        end
      end else if (m_st[k] == 1) begin
        if (di > 9) m_st[k] = 0;
        else if (di == m_exp[k]) begin
          m_run[k]++; m_exp[k] = nxt(di);
          if (m_run[k] == lc[k]) m_st[k] = 2;
        end else begin
          m_run[k] = 1; m_exp[k] = nxt(di);
        end
      end else begin
        if (di == m_exp[k]) begin
          m_exp[k] = nxt(di);
          if (di == 9) begin wr = 1; m_tens[k] = (m_tens[k] + 1) % 10; end
        end else begin
          er = 1; m_tens[k] = 0;
          if (m_ec[k] < ecmax[k]) m_ec[k]++;
          if (di <= 9) begin
            m_run[k] = 1; m_exp[k] = nxt(di); m_st[k] = (lc[k] == 1) ? 2 : 1;
          end else m_st[k] = 0;
        end
      end
    end
    e.lk = (m_st[k] == 2); e.er = er; e.il = il; e.wr = wr;
    e.tens = 4'(m_tens[k]); e.ec = 8'(m_ec[k]);
  endtask

  // ---------------- checking ----------------
  function automatic obs_t get(input int k);
    obs_t o;
    case (k)
      0:       o = {b0.locked, b0.err, b0.illegal, b0.wrap, b0.tens, b0.err_cnt};
      1:       o = {b1.locked, b1.err, b1.illegal, b1.wrap, b1.tens, 6'd0, b1.err_cnt};
      default: o = {b2.locked, b2.err, b2.illegal, b2.wrap, b2.tens, b2.err_cnt};
    endcase
    return o;
  endfunction

  task automatic check(input int k, input obs_t e, input string tag);
    obs_t a;
    a = get(k);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s u%0d: got lk=%b er=%b il=%b wr=%b tens=%0d ec=%0d, want lk=%b er=%b il=%b wr=%b tens=%0d ec=%0d",
             tag, k, a.lk, a.er, a.il, a.wr, a.tens, a.ec, e.lk, e.er, e.il, e.wr, e.tens, e.ec);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] d, input logic v, input string tag);
    obs_t e;
    digit = d; valid = v;
    for (int k = 0; k < 3; k++) begin
      model(k, d, v, e);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      check(k, e, tag);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) check(k, obs_t'(0), tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last;
    logic [3:0] d;
    logic v;
    int r;

    reset = 1'b0; valid = 1'b0; digit = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) reset = 1'b1;

    // clean decades, lock on the third digit (u0/u1), first digit (u2)
    for (int rep = 0; rep < 3; rep++)
      for (int i = 0; i < 10; i++) step(4'(i), 1'b1, "clean");
    step(4'd0, 1'b1, "clean");
    check_val("tens_after_3_decades", int'(b0.tens), 3);
    check_val("locked_clean", int'(b0.locked), 1);

    // sequence break 5,6,8 then relock via 9,0
    for (int i = 1; i <= 6; i++) step(4'(i), 1'b1, "pre_break");
    step(4'd8, 1'b1, "break");
    check_val("err_cnt_after_break", int'(b0.err_cnt), 1);
    step(4'd9, 1'b1, "resync");
    step(4'd0, 1'b1, "relock");
    check_val("relocked", int'(b0.locked), 1);

    // illegal code while locked, then while hunting
    step(4'd1, 1'b1, "pre_illegal");
    step(4'd12, 1'b1, "illegal_locked");
    step(4'd12, 1'b1, "illegal_hunt");

    // gapped stream, junk on the bus during idle cycles
    d = 4'd3;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin step(d, 1'b1, "gap_v1"); d = (d == 4'd9) ? 4'd0 : d + 4'd1; end
      else step(4'd12, 1'b0, "gap_v0");
    end

    // repeated lock/break: err_cnt saturates on the 2-bit instance
    for (int i = 0; i < 6; i++) begin
      step(4'd0, 1'b1, "sat_seed");
      step(4'd1, 1'b1, "sat_run");
      step(4'd2, 1'b1, "sat_lock");
      step(4'd5, 1'b1, "sat_break");
    end
    check_val("err_cnt_sat_w2", int'(b1.err_cnt), 3);

    // reset in the middle of a locked stream
    for (int i = 3; i < 8; i++) step(4'(i), 1'b1, "pre_reset");
    reset = 1'b0; valid = 1'b0;
    model_reset();
    #1 check_reset("mid_reset");
    #2 reset = 1'b1;

    // first digit after release seeds; LOCK_COUNT=1 locks at once, 9 breaks it
    step(4'd7, 1'b1, "seed7");
    check_val("lc1_locked", int'(b2.locked), 1);
    step(4'd9, 1'b1, "lc1_break");
    check_val("lc1_err", int'(b2.err), 1);

    // mostly in-sequence random stream with occasional glitches and gaps
    last = 9;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 24);
      if (r == 0)      d = 4'($urandom_range(10, 15));
      else if (r == 1) d = 4'($urandom_range(0, 9));
      else             d = 4'(nxt(last));
      if (v && d <= 4'd9) last = int'(d);
      step(d, v, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
